seg_scan_decoder: RTL
=====================

// Module: seg_scan_decoder
// PURPOSE
//   Receive side of the 7-segment display interface. Samples a multiplexed segment
//   bus (segment lines plus one-hot digit select) and recovers the BCD digit shown
//   at each position, accepting a value only after it has been sampled repeatedly.
//   Sits between the display pins and the self-check/readback logic of the clock.
// PARAMETERS
//   NUM_DIGITS  4  number of multiplexed digit positions (>=1)
//   STABLE_CNT  3  consecutive identical samples required before a digit is committed (>=1)
// PORTS
//   clk          in   1             system clock, rising edge
//   rst          in   1             asynchronous, active-high reset
//   sample_en    in   1             strobe: seg/dig_sel are sampled this cycle
//   seg          in   7             segment lines {g,f,e,d,c,b,a}, bit0=a, active-high
//   dig_sel      in   NUM_DIGITS    digit select, one-hot, active-high
//   err_clr      in   1             clears the sticky error flags
//   digits       out  4*NUM_DIGITS  committed BCD per position; digit i = [4i+3:4i]
//   digit_valid  out  NUM_DIGITS    position has a committed value
//   update       out  1             1-cycle pulse: a committed digit changed
//   code_err     out  NUM_DIGITS    sticky: an unrecognised segment code was sampled
//   sel_err      out  1             sticky: dig_sel was not one-hot on a sample
// BEHAVIOUR
//   Reset: digits=0, digit_valid=0, update=0, code_err=0, sel_err=0; candidates and
//     counters 0. Reset is asynchronous and takes effect immediately, mid-sample too.
//   Decode table (seg -> value): 3f->0 06->1 5b->2 4f->3 66->4 6d->5 7d->6 07->7
//     7f->8 6f->9 00->BLANK (4'hF, a valid value). Any other code is invalid.
//   Per position i: candidate cand[i] (4b) and counter cnt[i] ($clog2(STABLE_CNT+1) b).
//   Sampling happens only on cycles where sample_en=1:
//   - dig_sel not one-hot (zero or >1 bit): sample discarded, sel_err<=1; no state change.
//   - invalid code at selected i: cnt[i]<=0, code_err[i]<=1; cand[i] unchanged.
//   - valid value v == cand[i] and cnt[i]!=0: cnt[i]<=min(cnt[i]+1, STABLE_CNT).
//   - otherwise (v != cand[i] or cnt[i]==0): cand[i]<=v, cnt[i]<=1.
//   Commit: when the new count equals STABLE_CNT, digits[i]<=v and digit_valid[i]<=1
//     in the same edge (1-cycle latency after the qualifying sample). update pulses
//     for exactly the following cycle only if digits[i] changed or digit_valid[i]
//     rose. Saturated repeats leave outputs unchanged and produce no pulse.
//   STABLE_CNT=1: every valid sample commits immediately.
//   Invalid or changing samples never clear a committed digit or digit_valid.
//   Non-selected positions hold all state. Samples with sample_en=0 are ignored.
//   err_clr=1 clears code_err and sel_err; a new error in the same cycle wins (flag stays 1).
// CONFIGURATION
//   SEG_SCAN_DP_EN defined: adds input seg_dp (1b, decimal point) and output
//     dp_out (NUM_DIGITS). seg_dp is sampled with seg; stability compare covers
//     {seg_dp,v}; dp_out[i] is committed together with digits[i]; a dp change
//     alone restarts the count and, once committed, pulses update.
//   Not defined: no seg_dp/dp_out ports; decimal point is not observed.
// STRUCTURE
//   Package seg_scan_pkg: 7-bit segment code constants SEG_0..SEG_9, SEG_BLANK,
//     BCD_BLANK=4'hF, and a decode-result typedef {logic valid; logic [3:0] value}.
//   Sub-module seg7_to_bcd: combinational seg -> {valid,value}, using the package table.
//   Top: one-hot check, per-position candidate/counter array, commit and error logic.
// TESTING
//   Reset, then digit0 seg=6d on 3 samples -> after 3rd: digits[3:0]=5,
//     digit_valid[0]=1, update pulse 1 cycle; 2 samples only -> no commit.
//   Commit 5 on digit0, then 7d,7d,6d,6d,6d -> stays 5, no pulse until third 6d;
//     then 5 again on that edge, no update (unchanged).
//   Digit2 seg=7e -> code_err[2]=1, cnt reset, committed digit unchanged; err_clr with
//     simultaneous new bad code -> code_err stays 1; err_clr alone -> 0.
//   dig_sel=4'b0011 and 4'b0000 with sample_en -> sel_err=1, no digit state change.
//   Round-robin all 4 digits showing 1,2,3,BLANK x3 -> digits=16'hF321, valid=4'hF;
//     assert rst mid-sequence -> all outputs 0 immediately.
//   SEG_SCAN_DP_EN: digit1 seg=7f, seg_dp=1 x3 -> digits[7:4]=8, dp_out[1]=1;
//     flip dp only x3 -> dp_out[1]=0 with update pulse.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared segment-code table and decode result type for the 7-segment scan receiver.
package seg_scan_pkg;

  localparam logic [6:0] SEG_0     = 7'h3f;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5b;
  localparam logic [6:0] SEG_3     = 7'h4f;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6d;
  localparam logic [6:0] SEG_6     = 7'h7d;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7f;
  localparam logic [6:0] SEG_9     = 7'h6f;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef struct packed {
    logic       valid;
    logic [3:0] value;
  } seg_dec_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational 7-segment pattern to BCD decoder; unknown patterns flag valid=0.
module seg7_to_bcd
  import seg_scan_pkg::*;
(
  input  logic [6:0] seg_i,
  output seg_dec_t   dec_o
);

  always_comb begin
    dec_o.valid = 1'b1;
    dec_o.value = 4'h0;
    unique case (seg_i)
      SEG_0:     dec_o.value = 4'd0;
      SEG_1:     dec_o.value = 4'd1;
      SEG_2:     dec_o.value = 4'd2;
      SEG_3:     dec_o.value = 4'd3;
      SEG_4:     dec_o.value = 4'd4;
      SEG_5:     dec_o.value = 4'd5;
      SEG_6:     dec_o.value = 4'd6;
      SEG_7:     dec_o.value = 4'd7;
      SEG_8:     dec_o.value = 4'd8;
      SEG_9:     dec_o.value = 4'd9;
      SEG_BLANK: dec_o.value = BCD_BLANK;
      default:   dec_o.valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers debounced BCD digits from a multiplexed 7-segment bus.
// Optional decimal-point capture is enabled by defining SEG_SCAN_DP_EN.
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    sample_en_i,
  input  logic [6:0]              seg_i,
  input  logic [NUM_DIGITS-1:0]   dig_sel_i,
  input  logic                    err_clr_i,
`ifdef SEG_SCAN_DP_EN
  input  logic                    seg_dp_i,
  output logic [NUM_DIGITS-1:0]   dp_out_o,
`endif
  output logic [4*NUM_DIGITS-1:0] digits_o,
  output logic [NUM_DIGITS-1:0]   digit_valid_o,
  output logic                    update_o,
  output logic [NUM_DIGITS-1:0]   code_err_o,
  output logic                    sel_err_o
);

  localparam int unsigned CntW = $clog2(STABLE_CNT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CNT);
`ifdef SEG_SCAN_DP_EN
  localparam int unsigned KeyW = 5;
`else
  localparam int unsigned KeyW = 4;
`endif

  seg_dec_t dec;
  seg7_to_bcd u_dec (
    .seg_i (seg_i),
    .dec_o (dec)
  );

  // Key is what stability and commit compare: BCD value, plus dp when observed.
  logic [KeyW-1:0] key;
`ifdef SEG_SCAN_DP_EN
  assign key = {seg_dp_i, dec.value};
`else
  assign key = dec.value;
`endif

  logic [NUM_DIGITS-1:0] sel_m1;
  logic                  sel_onehot;
  assign sel_m1     = dig_sel_i - NUM_DIGITS'(1);
  assign sel_onehot = (dig_sel_i != '0) && ((dig_sel_i & sel_m1) == '0);

  logic [KeyW-1:0]       cand_q [NUM_DIGITS];
  logic [KeyW-1:0]       cand_d [NUM_DIGITS];
  logic [CntW-1:0]       cnt_q  [NUM_DIGITS];
  logic [CntW-1:0]       cnt_d  [NUM_DIGITS];
  logic [KeyW-1:0]       com_q  [NUM_DIGITS];
  logic [KeyW-1:0]       com_d  [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] valid_q, valid_d;
  logic [NUM_DIGITS-1:0] code_err_q, code_err_d;
  logic                  sel_err_q, sel_err_d;
  logic                  update_q, update_d;
  logic [CntW-1:0]       new_cnt;

  always_comb begin
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    com_d      = com_q;
    valid_d    = valid_q;
    update_d   = 1'b0;
    new_cnt    = '0;
    // Clear first so that an error detected this cycle overrides err_clr.
    code_err_d = err_clr_i ? '0 : code_err_q;
    sel_err_d  = err_clr_i ? 1'b0 : sel_err_q;
    if (sample_en_i) begin
      if (!sel_onehot) begin
        sel_err_d = 1'b1;
      end else begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (dig_sel_i[i]) begin
            if (!dec.valid) begin
              cnt_d[i]      = '0;
              code_err_d[i] = 1'b1;
            end else begin
              if (key == cand_q[i] && cnt_q[i] != '0) begin
                new_cnt = (cnt_q[i] == CntMax) ? CntMax : cnt_q[i] + CntW'(1);
              end else begin
                new_cnt = CntW'(1);
              end
              cand_d[i] = key;
              cnt_d[i]  = new_cnt;
              if (new_cnt == CntMax) begin
                update_d   = !valid_q[i] || (com_q[i] != key);
                com_d[i]   = key;
                valid_d[i] = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        cand_q[i] <= '0;
        cnt_q[i]  <= '0;
        com_q[i]  <= '0;
      end
      valid_q    <= '0;
      code_err_q <= '0;
      sel_err_q  <= 1'b0;
      update_q   <= 1'b0;
    end else begin
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      com_q      <= com_d;
      valid_q    <= valid_d;
      code_err_q <= code_err_d;
      sel_err_q  <= sel_err_d;
      update_q   <= update_d;
    end
  end

  always_comb begin
    digits_o = '0;
`ifdef SEG_SCAN_DP_EN
    dp_out_o = '0;
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digits_o[i*4 +: 4] = com_q[i][3:0];
`ifdef SEG_SCAN_DP_EN
      dp_out_o[i] = com_q[i][4];
`endif
    end
  end

  assign digit_valid_o = valid_q;
  assign update_o      = update_q;
  assign code_err_o    = code_err_q;
  assign sel_err_o     = sel_err_q;

endmodule
